// File: rtl/apb3_stream_requester.sv
// apb3_stream_requester
//   Turns a valid/ready command stream into single APB3 transfers. Each result
//   comes back on a valid/ready response stream. PREADY wait states are
//   supported, and an optional timeout aborts a transfer that the completer
//   never finishes.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_addr/cmd_write/cmd_wdata   command payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_error/rsp_timeout response payload
//   paddr/pselx/penable/pwrite/pwdata  APB3 request (registered)
//   pready/prdata/pslverr          APB3 completer reply
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a command; cmd_ready high
// SETUP  | APB setup phase, pselx=1 penable=0, one cycle
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | response held on rsp_* until rsp_ready
module apb3_stream_requester #(
   parameter int AddressWidth  = 20,
   parameter int DataWidth     = 32,
   parameter int TimeoutCycles = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [AddressWidth-1:0] cmd_addr,
   input  logic                    cmd_write,
   input  logic [DataWidth-1:0]    cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DataWidth-1:0]    rsp_rdata,
   output logic                    rsp_error,
   output logic                    rsp_timeout,
   output logic [AddressWidth-1:0] paddr,
   output logic                    pselx,
   output logic                    penable,
   output logic                    pwrite,
   output logic [DataWidth-1:0]    pwdata,
   input  logic                    pready,
   input  logic [DataWidth-1:0]    prdata,
   input  logic                    pslverr
);

   localparam bit TimeoutEn = (TimeoutCycles != 0);
   localparam int CntW      = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutEn ? TimeoutCycles - 1 : 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                  state_q;
   logic [CntW-1:0]         cnt_q;
   logic [AddressWidth-1:0] paddr_q;
   logic                    pselx_q;
   logic                    penable_q;
   logic                    pwrite_q;
   logic [DataWidth-1:0]    pwdata_q;
   logic                    rsp_valid_q;
   logic [DataWidth-1:0]    rsp_rdata_q;
   logic                    rsp_error_q;
   logic                    rsp_timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         paddr_q       <= '0;
         pselx_q       <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_error_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  paddr_q   <= cmd_addr;
                  pwrite_q  <= cmd_write;
                  pwdata_q  <= cmd_write ? cmd_wdata : '0;
                  pselx_q   <= 1'b1;
                  penable_q <= 1'b0;
                  state_q   <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               cnt_q     <= '0;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                  rsp_error_q   <= pslverr;
                  rsp_timeout_q <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  pselx_q       <= 1'b0;
                  penable_q     <= 1'b0;
                  state_q       <= RESP;
               end else if (TimeoutEn && cnt_q == CntLast) begin
                  // cnt_q counts ACCESS cycles already spent, so this is the last allowed one
                  rsp_rdata_q   <= '0;
                  rsp_error_q   <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  rsp_valid_q   <= 1'b1;
                  pselx_q       <= 1'b0;
                  penable_q     <= 1'b0;
                  state_q       <= RESP;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Gate with rst_n so that no command is accepted while reset is held.
   assign cmd_ready   = rst_n & (state_q == IDLE);
   assign paddr       = paddr_q;
   assign pselx       = pselx_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_stream_requester.sv
module tb_apb3_stream_requester;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [19:0] cmd_addr = '0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        rsp_timeout;
   logic [19:0] paddr;
   logic        pselx;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready = 1'b0;
   logic [31:0] prdata = '0;
   logic        pslverr = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [19:0] last_addr = '0;

   apb3_stream_requester #(
      .AddressWidth (20),
      .DataWidth    (32),
      .TimeoutCycles(TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_write  (cmd_write),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_error  (rsp_error),
      .rsp_timeout(rsp_timeout),
      .paddr      (paddr),
      .pselx      (pselx),
      .penable    (penable),
      .pwrite     (pwrite),
      .pwdata     (pwdata),
      .pready     (pready),
      .prdata     (prdata),
      .pslverr    (pslverr)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk20(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rand_cmd();
      cmd_addr  = 20'($urandom);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_wdata = $urandom;
   endtask

   // One complete transfer, called in an IDLE cycle just after a falling edge.
   // waits = ACCESS cycles with pready low before it rises; waits >= TO never completes.
   // hold  = cycles the response is left unconsumed.
   task automatic xfer(input logic [19:0] a, input logic w, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd, input logic err, input int hold);
      logic        to;
      logic [31:0] e_rd;
      logic        e_err;
      logic [31:0] e_wd;
      int          n_acc;
      to    = (waits >= TO);
      e_rd  = (w || to) ? 32'h0 : rd;
      e_err = to ? 1'b1 : err;
      e_wd  = w ? wd : 32'h0;
      n_acc = to ? TO : waits + 1;
      last_addr = a;

      chk1("idle_cmd_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = wd;
      pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;

      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      rand_cmd();
      chk1("setup_pselx", pselx, 1'b1);
      chk1("setup_penable", penable, 1'b0);
      chk20("setup_paddr", paddr, a);
      chk1("setup_pwrite", pwrite, w);
      chk32("setup_pwdata", pwdata, e_wd);
      chk1("setup_rsp_valid", rsp_valid, 1'b0);
      chk1("setup_cmd_ready", cmd_ready, 1'b0);
      // reply during SETUP must be ignored
      pready = 1'b1; pslverr = 1'b1; prdata = $urandom;

      for (int c = 0; c < n_acc; c++) begin
         @(negedge clk);
         chk1("access_pselx", pselx, 1'b1);
         chk1("access_penable", penable, 1'b1);
         chk20("access_paddr", paddr, a);
         chk1("access_pwrite", pwrite, w);
         chk32("access_pwdata", pwdata, e_wd);
         chk1("access_rsp_valid", rsp_valid, 1'b0);
         chk1("access_cmd_ready", cmd_ready, 1'b0);
         pready  = (c == waits);
         prdata  = (c == waits) ? rd : $urandom;
         pslverr = (c == waits) ? err : 1'($urandom_range(0, 1));
      end

      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         chk1("rsp_valid", rsp_valid, 1'b1);
         chk32("rsp_rdata", rsp_rdata, e_rd);
         chk1("rsp_error", rsp_error, e_err);
         chk1("rsp_timeout", rsp_timeout, to);
         chk1("rsp_pselx", pselx, 1'b0);
         chk1("rsp_penable", penable, 1'b0);
         chk1("rsp_cmd_ready", cmd_ready, 1'b0);
         rsp_ready = (h == hold);
         cmd_valid = 1'b1;
         rand_cmd();
         pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
      end

      @(negedge clk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      chk1("done_rsp_valid", rsp_valid, 1'b0);
      chk1("done_pselx", pselx, 1'b0);
      chk20("done_paddr_held", paddr, a);
   endtask

   task automatic idle_check(input int n, input logic force_rdy);
      for (int i = 0; i < n; i++) begin
         cmd_valid = 1'b0;
         pready  = force_rdy ? 1'b1 : 1'($urandom_range(0, 1));
         pslverr = 1'($urandom_range(0, 1));
         prdata  = $urandom;
         @(negedge clk);
         chk1("idle_pselx", pselx, 1'b0);
         chk1("idle_penable", penable, 1'b0);
         chk1("idle_rsp_valid", rsp_valid, 1'b0);
         chk1("idle_cmd_ready", cmd_ready, 1'b1);
         chk20("idle_paddr", paddr, last_addr);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk1("rst_pselx", pselx, 1'b0);
      chk1("rst_penable", penable, 1'b0);
      chk1("rst_pwrite", pwrite, 1'b0);
      chk20("rst_paddr", paddr, 20'h0);
      chk32("rst_pwdata", pwdata, 32'h0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk1("rst_rsp_error", rsp_error, 1'b0);
      chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
      chk1("rst_cmd_ready", cmd_ready, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 chk1("post_rst_cmd_ready", cmd_ready, 1'b1);
      idle_check(2, 1'b0);

      // plain write, no wait states
      xfer(20'h00010, 1'b1, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0);
      // read with three wait states
      xfer(20'h00024, 1'b0, 32'h0, 3, 32'h12345678, 1'b0, 0);
      // slave error on write, then a clean read
      xfer(20'h00030, 1'b1, 32'h0BADF00D, 0, 32'h0, 1'b1, 1);
      xfer(20'h00034, 1'b0, 32'h0, 1, 32'hA5A55A5A, 1'b0, 0);
      // longest wait that still completes, then a timeout
      xfer(20'h00038, 0, 32'h0, TO - 1, 32'h55AA33CC, 1'b1, 0);
      xfer(20'h00040, 1'b0, 32'h0, TO, 32'hFFFFFFFF, 1'b0, 0);
      idle_check(3, 1'b1);
      // response back-pressure while commands keep arriving
      xfer(20'h00050, 1'b0, 32'h0, 0, 32'h0F0F0F0F, 1'b0, 5);
      xfer(20'h00054, 1'b1, 32'h11223344, 2, 32'h0, 1'b0, 0);

      // reset in the middle of ACCESS
      cmd_valid = 1'b1; cmd_addr = 20'h0ABCD; cmd_write = 1'b1; cmd_wdata = 32'hCAFEF00D; pready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk1("pre_rst_penable", penable, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk1("midrst_pselx", pselx, 1'b0);
      chk1("midrst_penable", penable, 1'b0);
      chk1("midrst_rsp_valid", rsp_valid, 1'b0);
      chk1("midrst_cmd_ready", cmd_ready, 1'b0);
      chk20("midrst_paddr", paddr, 20'h0);
      chk32("midrst_pwdata", pwdata, 32'h0);
      pready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk1("rel_cmd_ready", cmd_ready, 1'b1);
      last_addr = 20'h0;
      idle_check(10, 1'b0);

      // randomized transfers against the rule-based model inside xfer
      for (int t = 0; t < 30; t++) begin
         xfer(20'($urandom), 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, TO + 2), $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
      end
      idle_check(2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
